fetch_stage_ctrl: RTL and testbench

Consumer end of the load-use stall interface. Owns the program counter and the IF/ID pipeline buffer, and applies pc_pause, if_id_hold and if_id_flush from the hazard unit. Also applies branch redirects from EX and a halt state. Sits between instruction memory and the ID stage of the 16-bit pipelined CPU.

---
 rtl/fetch_stage_ctrl.sv | 80 ++++++++
 tb/tb_fetch_stage_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the PC and the IF/ID buffer, and applies hazard-unit
// stall/flush controls, EX-stage branch redirects and a halt-on-opcode state.
module fetch_stage_ctrl #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF,
    parameter int              CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_pause,
    input  logic               if_id_hold,
    input  logic               if_id_flush,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0] state;
    logic       normal_load;
    logic       halt_trigger;

    // A halt opcode only counts when it is actually captured into IF/ID.
    assign normal_load  = !if_id_hold && !if_id_flush;
    assign halt_trigger = normal_load && (imem_instr[INSTR_W-1 -: 4] == HALT_OP);
    assign halted       = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (branch_taken) begin
            state       <= ST_RUN;
            pc          <= branch_target;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
            if (flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end else if (state == ST_HALT) begin
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else begin
            // Hold wins over flush: the load-use bubble belongs in ID/EX.
            if (if_id_hold) begin
                if (stall_count != '1)
                    stall_count <= stall_count + CNT_W'(1);
            end else if (if_id_flush) begin
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
                if (flush_count != '1)
                    flush_count <= flush_count + CNT_W'(1);
            end else begin
                if_id_instr <= imem_instr;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                if (halt_trigger)
                    state <= ST_HALT;
            end
            if (!pc_pause && !halt_trigger)
                pc <= pc + PC_W'(2);
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed vector table, a long
// hold for counter saturation, then random stimulus against a behavioural model.
module tb_fetch_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst, pc_pause, if_id_hold, if_id_flush, branch_taken;
    logic [15:0] branch_target, imem_instr;
    logic [15:0] pc, if_id_instr, if_id_pc, stall_count, flush_count;
    logic        if_id_valid, halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage_ctrl dut (
        .clk(clk), .rst(rst), .pc_pause(pc_pause), .if_id_hold(if_id_hold),
        .if_id_flush(if_id_flush), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        logic        r, p, h, f, b;
        logic [15:0] target, instr;
        logic [15:0] e_pc, e_instr, e_ifpc;
        logic        e_valid, e_halted;
        logic [15:0] e_stall, e_flush;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        int pc, instr, ifpc, stall, flush;
        bit valid, halted;
    } model_t;

    function automatic void add(input logic r, p, h, f, b, input logic [15:0] t, i,
                                input logic [15:0] epc, einstr, eifpc,
                                input logic ev, eh, input logic [15:0] es, ef);
        vec_t v;
        v.r = r; v.p = p; v.h = h; v.f = f; v.b = b; v.target = t; v.instr = i;
        v.e_pc = epc; v.e_instr = einstr; v.e_ifpc = eifpc;
        v.e_valid = ev; v.e_halted = eh; v.e_stall = es; v.e_flush = ef;
        vecs.push_back(v);
    endfunction

    // Spec-level reference: one clock of the fetch stage in plain arithmetic.
    function automatic model_t model_step(input model_t m, input bit r, p, h, f, b,
                                          input int t, input int i);
        model_t n;
        bit     halting;
        n = m;
        halting = 1'b0;
        if (r) begin
            n.pc = 0; n.instr = 0; n.ifpc = 0; n.stall = 0; n.flush = 0;
            n.valid = 0; n.halted = 0;
        end else if (b) begin
            n.pc = t; n.instr = 0; n.valid = 0; n.halted = 0;
            n.flush = (m.flush >= 65535) ? 65535 : m.flush + 1;
        end else if (m.halted) begin
            n.instr = 0; n.valid = 0;
        end else begin
            if (h) begin
                n.stall = (m.stall >= 65535) ? 65535 : m.stall + 1;
            end else if (f) begin
                n.instr = 0; n.valid = 0;
                n.flush = (m.flush >= 65535) ? 65535 : m.flush + 1;
            end else begin
                halting  = ((i / 4096) == 15);
                n.instr  = i; n.ifpc = m.pc; n.valid = 1; n.halted = halting;
            end
            if (!p && !halting) n.pc = (m.pc + 2) % 65536;
        end
        return n;
    endfunction

    task applyStimulus(input logic r, p, h, f, b, input logic [15:0] t, i);
        rst = r; pc_pause = p; if_id_hold = h; if_id_flush = f;
        branch_taken = b; branch_target = t; imem_instr = i;
        @(posedge clk);
        #1;
    endtask

    task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task checkAll(input string tag, input logic [15:0] epc, einstr, eifpc,
                  input logic ev, eh, input logic [15:0] es, ef);
        checkOutput({tag, "_pc"},    32'(pc),          32'(epc));
        checkOutput({tag, "_instr"}, 32'(if_id_instr), 32'(einstr));
        checkOutput({tag, "_ifpc"},  32'(if_id_pc),    32'(eifpc));
        checkOutput({tag, "_valid"}, 32'(if_id_valid), 32'(ev));
        checkOutput({tag, "_halt"},  32'(halted),      32'(eh));
        checkOutput({tag, "_stall"}, 32'(stall_count), 32'(es));
        checkOutput({tag, "_flush"}, 32'(flush_count), 32'(ef));
    endtask

    initial begin
        model_t m;
        bit     r, p, h, f, b;
        int     t, i;

        //   r  p  h  f  b  target    instr     pc        instr     ifpc      v  h  stall  flush
        add(1, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0000, 1, 0, 16'd0, 16'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0004, 16'h1234, 16'h0002, 1, 0, 16'd0, 16'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0006, 16'h1234, 16'h0004, 1, 0, 16'd0, 16'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0008, 16'h1234, 16'h0006, 1, 0, 16'd0, 16'd0);
        add(0, 1, 1, 1, 0, 16'h0000, 16'h1234, 16'h0008, 16'h1234, 16'h0006, 1, 0, 16'd1, 16'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h5678, 16'h000A, 16'h5678, 16'h0008, 1, 0, 16'd1, 16'd0);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h9999, 16'h000C, 16'h0000, 16'h0008, 0, 0, 16'd1, 16'd1);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h1111, 16'h000E, 16'h1111, 16'h000C, 1, 0, 16'd1, 16'd1);
        add(0, 1, 1, 0, 1, 16'h0040, 16'h7777, 16'h0040, 16'h0000, 16'h000C, 0, 0, 16'd1, 16'd2);
        add(0, 1, 0, 0, 0, 16'h0000, 16'h2222, 16'h0040, 16'h2222, 16'h0040, 1, 0, 16'd1, 16'd2);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h3333, 16'h0042, 16'h3333, 16'h0040, 1, 0, 16'd1, 16'd2);
        add(0, 0, 0, 0, 1, 16'h0010, 16'h3333, 16'h0010, 16'h0000, 16'h0040, 0, 0, 16'd1, 16'd3);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF000, 16'h0010, 16'hF000, 16'h0010, 1, 1, 16'd1, 16'd3);
        add(0, 0, 1, 1, 0, 16'h0000, 16'h1234, 16'h0010, 16'h0000, 16'h0010, 0, 1, 16'd1, 16'd3);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF000, 16'h0010, 16'h0000, 16'h0010, 0, 1, 16'd1, 16'd3);
        add(0, 0, 0, 0, 1, 16'hFFFE, 16'hF000, 16'hFFFE, 16'h0000, 16'h0010, 0, 0, 16'd1, 16'd4);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h4444, 16'h0000, 16'h4444, 16'hFFFE, 1, 0, 16'd1, 16'd4);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h5555, 16'h0002, 16'h5555, 16'h0000, 1, 0, 16'd1, 16'd4);
        add(0, 0, 1, 0, 0, 16'h0000, 16'hF123, 16'h0004, 16'h5555, 16'h0000, 1, 0, 16'd2, 16'd4);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h6666, 16'h0006, 16'h6666, 16'h0004, 1, 0, 16'd2, 16'd4);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF001, 16'h0006, 16'hF001, 16'h0006, 1, 1, 16'd2, 16'd4);
        add(1, 0, 1, 0, 1, 16'h0080, 16'hF001, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].r, vecs[k].p, vecs[k].h, vecs[k].f, vecs[k].b,
                          vecs[k].target, vecs[k].instr);
            checkAll($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_instr, vecs[k].e_ifpc,
                     vecs[k].e_valid, vecs[k].e_halted, vecs[k].e_stall, vecs[k].e_flush);
        end

        // Long load-use hold drives stall_count into saturation.
        for (int k = 0; k < 65540; k++)
            applyStimulus(0, 1, 1, 0, 0, 16'h0000, 16'hABCD);
        checkAll("sat", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0000);
        applyStimulus(0, 0, 1, 1, 0, 16'h0000, 16'hABCD);
        checkAll("sat_more", 16'h0002, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0000);

        // Randomised phase against the reference model.
        applyStimulus(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
        m = model_step(m, 1, 0, 0, 0, 0, 0, 0);
        checkAll("rnd_reset", 16'(m.pc), 16'(m.instr), 16'(m.ifpc), m.valid, m.halted,
                 16'(m.stall), 16'(m.flush));
        for (int k = 0; k < 2000; k++) begin
            r = ($urandom_range(0, 199) == 0);
            p = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = int'($urandom_range(0, 32767)) * 2;
            i = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 5) == 0) i = 61440 + (i % 4096);
            applyStimulus(r, p, h, f, b, 16'(t), 16'(i));
            m = model_step(m, r, p, h, f, b, t, i);
            checkAll("rnd", 16'(m.pc), 16'(m.instr), 16'(m.ifpc), m.valid, m.halted,
                     16'(m.stall), 16'(m.flush));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
